prf_mp: RTL and testbench
=========================

PRF_MP -- requirements
Module: prf_mp

Interface
REQ-001 SHALL have parameters, one per line:
  PHYS_REGS, 64, number of physical registers
  DW, 32, data width
  NUM_RD, 4, read-port pairs
  NUM_WB, 2, writeback ports
  NUM_ALLOC, 2, allocation ports
  EPOCH_W, 2, epoch tag width
  SWEEP_PER_CYC, 8, entries examined per sweep cycle; PHYS_REGS is a multiple of it
  PHYS_W, $clog2(PHYS_REGS), index width
REQ-002 SHALL have ports, one per line:
  clk  in  1  clock, rising edge
  rst  in  1  reset, asynchronous, active-high
  raddr1  in  NUM_RD x PHYS_W  source-1 read indices
  rdata1 / rready1  out  NUM_RD x DW / NUM_RD x 1  source-1 data and ready bit
  raddr2  in  NUM_RD x PHYS_W  source-2 read indices
  rdata2 / rready2  out  NUM_RD x DW / NUM_RD x 1  source-2 data and ready bit
  alloc_valid / alloc_pd / alloc_epoch  in  NUM_ALLOC x (1 / PHYS_W / EPOCH_W)  rename allocation
  wb_valid / wb_pd / wb_data / wb_epoch  in  NUM_WB x (1 / PHYS_W / DW / EPOCH_W)  writeback
  sweep_start / sweep_epoch  in  1 / EPOCH_W  begin orphan sweep for the surviving epoch
  sweep_busy  out  1  sweep in progress
  wb_conflict  out  1  registered pulse, duplicate writeback target
  ready_vec  out  PHYS_REGS  all ready bits

Function
REQ-003 SHALL perform combinational reads: rdata = mem[raddr], rready = ready[raddr].
REQ-004 SHALL, per valid alloc port, clear ready[pd] and set epoch[pd] = alloc_epoch at the next edge.
REQ-005 SHALL let the highest-index alloc port win when two alloc ports name the same pd.
REQ-006 SHALL accept a writeback only when wb_epoch equals the stored epoch[wb_pd] as it was before this edge. An accepted writeback writes mem and sets ready.
REQ-007 SHALL drop stale writebacks silently, leaving mem, ready and epoch unchanged.
REQ-008 SHALL let an accepted writeback override a same-cycle alloc of the same pd for the ready bit. The alloc epoch is still written.
REQ-009 SHALL let the lowest-index port win when two accepted writebacks target the same pd, and SHALL assert wb_conflict for exactly one cycle after that edge.
REQ-010 SHALL implement the sweep FSM with states IDLE and SWEEP:
  - IDLE->SWEEP on sweep_start: latch sweep_epoch, idx=0.
  - In SWEEP, each cycle examines entries idx..idx+SWEEP_PER_CYC-1. Any with ready==0 and epoch!=latched epoch is set ready=1; data is unchanged.
  - idx advances by SWEEP_PER_CYC; after the last block, SWEEP->IDLE.
  - Sweep lasts PHYS_REGS/SWEEP_PER_CYC cycles.
REQ-011 SHALL hold sweep_busy=1 exactly while in SWEEP, and SHALL ignore sweep_start while busy.
REQ-012 SHALL give same-cycle alloc and writeback priority over sweep for the same entry.
REQ-013 SHALL drive ready_vec[i] = ready[i] combinationally.

Reset
REQ-014 SHALL, while rst=1, asynchronously clear mem to 0, set ready to all 1, set epoch to all 0, put the FSM in IDLE, clear idx, and hold sweep_busy=0 and wb_conflict=0.
REQ-015 SHALL, when rst asserts mid-sweep, abort the sweep and end in IDLE.

Configuration
REQ-016 SHALL, when macro PRF_BYPASS_EN is defined, forward same-cycle accepted writebacks to matching read ports: rdata=wb_data, rready=1, using the lowest-index matching port.
REQ-017 SHALL, without PRF_BYPASS_EN, make writeback data visible to reads only from the cycle after the edge.

Verification
REQ-018 Reset, then read pd 5 -> rdata=0, rready=1, ready_vec=all ones.
REQ-019 Alloc pd 7 with epoch 1, then wb pd 7 with epoch 1, data 0xDEADBEEF -> next cycle rready=1, rdata=0xDEADBEEF. A following wb pd 7 with epoch 0 is dropped.
REQ-020 Same cycle: wb[0] and wb[1] both accepted for pd 9, data 0x11 and 0x22 -> mem[9]=0x11, wb_conflict high for one cycle.
REQ-021 Alloc pd 3 (epoch 2) and pd 4 (epoch 1), then sweep_start with epoch 1 -> sweep_busy high for 8 cycles (64/8), then ready[3]=1, ready[4]=0.
REQ-022 PRF_BYPASS_EN defined: wb pd 12, data 0x55, while raddr1[0]=12 -> same-cycle rdata1[0]=0x55, rready1[0]=1. Macro undefined -> old value that cycle.
REQ-023 Assert rst during cycle 3 of a sweep -> sweep_busy=0 immediately, and all ready bits read 1.

Source files
------------

// File: rtl/prf_mp.sv
// -----------------------------------------------------------------------------
// prf_mp : multi-ported physical register file with per-entry ready bits,
//          epoch tags and a background orphan sweep.
//
// Purpose
//   Holds PHYS_REGS data words. Each entry also has a ready bit and an epoch
//   tag. A rename allocation clears the ready bit and stamps a new epoch. A
//   writeback is accepted only when its epoch matches the stored tag;
//   mismatching (stale) writebacks are dropped. A sweep walks the file
//   SWEEP_PER_CYC entries per cycle. It marks ready any not-ready entry whose
//   epoch differs from the surviving epoch, which releases its waiters.
//
// Ports
//   clk, rst                     clock (rising edge), async active-high reset
//   raddr1/rdata1/rready1        NUM_RD source-1 read ports (combinational)
//   raddr2/rdata2/rready2        NUM_RD source-2 read ports (combinational)
//   alloc_valid/_pd/_epoch       NUM_ALLOC allocation ports
//   wb_valid/_pd/_data/_epoch    NUM_WB writeback ports
//   sweep_start/sweep_epoch      request an orphan sweep for the surviving epoch
//   sweep_busy                   high while the sweep walks the file
//   wb_conflict                  one-cycle pulse after two accepted writebacks
//                                hit the same entry
//   ready_vec                    all ready bits
//
// Configuration
//   PRF_BYPASS_EN : when defined, an accepted writeback is forwarded to
//                   matching read ports in the same cycle. The lowest-index
//                   writeback port wins.
// -----------------------------------------------------------------------------
module prf_mp #(
    parameter int PHYS_REGS     = 64,
    parameter int DW            = 32,
    parameter int NUM_RD        = 4,
    parameter int NUM_WB        = 2,
    parameter int NUM_ALLOC     = 2,
    parameter int EPOCH_W       = 2,
    parameter int SWEEP_PER_CYC = 8,
    parameter int PHYS_W        = $clog2(PHYS_REGS)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_RD-1:0][PHYS_W-1:0]        raddr1,
    output logic [NUM_RD-1:0][DW-1:0]            rdata1,
    output logic [NUM_RD-1:0]                    rready1,
    input  logic [NUM_RD-1:0][PHYS_W-1:0]        raddr2,
    output logic [NUM_RD-1:0][DW-1:0]            rdata2,
    output logic [NUM_RD-1:0]                    rready2,
    input  logic [NUM_ALLOC-1:0]                 alloc_valid,
    input  logic [NUM_ALLOC-1:0][PHYS_W-1:0]     alloc_pd,
    input  logic [NUM_ALLOC-1:0][EPOCH_W-1:0]    alloc_epoch,
    input  logic [NUM_WB-1:0]                    wb_valid,
    input  logic [NUM_WB-1:0][PHYS_W-1:0]        wb_pd,
    input  logic [NUM_WB-1:0][DW-1:0]            wb_data,
    input  logic [NUM_WB-1:0][EPOCH_W-1:0]       wb_epoch,
    input  logic                                 sweep_start,
    input  logic [EPOCH_W-1:0]                   sweep_epoch,
    output logic                                 sweep_busy,
    output logic                                 wb_conflict,
    output logic [PHYS_REGS-1:0]                 ready_vec
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

    // Index of the first entry in the final sweep block.
    localparam logic [PHYS_W-1:0] LAST_IDX = PHYS_W'(PHYS_REGS - SWEEP_PER_CYC);
    localparam logic [PHYS_W-1:0] IDX_STEP = PHYS_W'(SWEEP_PER_CYC);

    state_e                 state_q, state_d;
    logic [PHYS_W-1:0]      idx_q, idx_d;
    logic [EPOCH_W-1:0]     sweep_ep_q, sweep_ep_d;
    logic [DW-1:0]          mem_q   [PHYS_REGS];
    logic [DW-1:0]          mem_d   [PHYS_REGS];
    logic [EPOCH_W-1:0]     epoch_q [PHYS_REGS];
    logic [EPOCH_W-1:0]     epoch_d [PHYS_REGS];
    logic [PHYS_REGS-1:0]   ready_q, ready_d;
    logic                   wb_conflict_q, wb_conflict_d;
    logic [NUM_WB-1:0]      wb_acc_s;

    // Writeback acceptance: epoch must match the tag held before this edge.
    always_comb begin
        wb_acc_s = '0;
        for (int w = 0; w < NUM_WB; w++) begin
            wb_acc_s[w] = wb_valid[w] && (wb_epoch[w] == epoch_q[wb_pd[w]]);
        end
    end

    // Duplicate-target detection among accepted writebacks.
    always_comb begin
        wb_conflict_d = 1'b0;
        for (int i = 0; i < NUM_WB; i++) begin
            for (int j = i + 1; j < NUM_WB; j++) begin
                if (wb_acc_s[i] && wb_acc_s[j] && (wb_pd[i] == wb_pd[j])) begin
                    wb_conflict_d = 1'b1;
                end else begin
                    wb_conflict_d = wb_conflict_d;
                end
            end
        end
    end

    // Next-state for the storage arrays. The lowest priority is applied first,
    // so later assignments override it: sweep, then alloc, then writeback.
    always_comb begin
        mem_d   = mem_q;
        epoch_d = epoch_q;
        ready_d = ready_q;
        if (state_q == ST_SWEEP) begin
            for (int j = 0; j < SWEEP_PER_CYC; j++) begin
                if (!ready_q[idx_q + PHYS_W'(j)] &&
                    (epoch_q[idx_q + PHYS_W'(j)] != sweep_ep_q)) begin
                    ready_d[idx_q + PHYS_W'(j)] = 1'b1;
                end else begin
                    ready_d[idx_q + PHYS_W'(j)] = ready_d[idx_q + PHYS_W'(j)];
                end
            end
        end else begin
            ready_d = ready_d;
        end
        // Ascending order so the highest-index alloc port lands last.
        for (int a = 0; a < NUM_ALLOC; a++) begin
            if (alloc_valid[a]) begin
                ready_d[alloc_pd[a]] = 1'b0;
                epoch_d[alloc_pd[a]] = alloc_epoch[a];
            end else begin
                ready_d = ready_d;
            end
        end
        // Descending order so the lowest-index writeback port lands last.
        for (int w = NUM_WB - 1; w >= 0; w--) begin
            if (wb_acc_s[w]) begin
                mem_d[wb_pd[w]]   = wb_data[w];
                ready_d[wb_pd[w]] = 1'b1;
            end else begin
                ready_d = ready_d;
            end
        end
    end

    // Sweep FSM next-state logic.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sweep_ep_d = sweep_ep_q;
        case (state_q)
            ST_IDLE: begin
                if (sweep_start) begin
                    state_d    = ST_SWEEP;
                    idx_d      = '0;
                    sweep_ep_d = sweep_epoch;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_STEP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Sweep FSM output decode.
    always_comb begin
        case (state_q)
            ST_SWEEP: sweep_busy = 1'b1;
            ST_IDLE:  sweep_busy = 1'b0;
            default:  sweep_busy = 1'b0;
        endcase
    end

    // State register for FSM, storage arrays and the conflict pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            sweep_ep_q    <= '0;
            ready_q       <= '1;
            wb_conflict_q <= 1'b0;
            for (int i = 0; i < PHYS_REGS; i++) begin
                mem_q[i]   <= '0;
                epoch_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            sweep_ep_q    <= sweep_ep_d;
            ready_q       <= ready_d;
            wb_conflict_q <= wb_conflict_d;
            mem_q         <= mem_d;
            epoch_q       <= epoch_d;
        end
    end

    // Combinational read ports, with optional same-cycle writeback forwarding.
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rdata1[p]  = mem_q[raddr1[p]];
            rready1[p] = ready_q[raddr1[p]];
            rdata2[p]  = mem_q[raddr2[p]];
            rready2[p] = ready_q[raddr2[p]];
        end
`ifdef PRF_BYPASS_EN
        for (int p = 0; p < NUM_RD; p++) begin
            for (int w = NUM_WB - 1; w >= 0; w--) begin
                if (wb_acc_s[w] && (wb_pd[w] == raddr1[p])) begin
                    rdata1[p]  = wb_data[w];
                    rready1[p] = 1'b1;
                end else begin
                    rready1[p] = rready1[p];
                end
                if (wb_acc_s[w] && (wb_pd[w] == raddr2[p])) begin
                    rdata2[p]  = wb_data[w];
                    rready2[p] = 1'b1;
                end else begin
                    rready2[p] = rready2[p];
                end
            end
        end
`else
        rdata1 = rdata1;
`endif
    end

    assign ready_vec   = ready_q;
    assign wb_conflict = wb_conflict_q;

endmodule

// File: tb/tb_prf_mp.sv
// -----------------------------------------------------------------------------
// tb_prf_mp : scoreboard bench for prf_mp. A behavioural model predicts every
// cycle's visible outputs, and a negedge monitor compares them. Directed
// sequences exercise the register-file scenarios. Randomized traffic follows
// them.
// -----------------------------------------------------------------------------
module tb_prf_mp;

    localparam int PHYS_REGS = 64;
    localparam int DW        = 32;
    localparam int NUM_RD    = 4;
    localparam int NUM_WB    = 2;
    localparam int NUM_ALLOC = 2;
    localparam int EPOCH_W   = 2;
    localparam int SPC       = 8;
    localparam int PHYS_W    = $clog2(PHYS_REGS);
    localparam int NBLK      = PHYS_REGS / SPC;

    logic                              clk = 1'b0;
    logic                              rst;
    logic [NUM_RD-1:0][PHYS_W-1:0]     raddr1, raddr2;
    logic [NUM_RD-1:0][DW-1:0]         rdata1, rdata2;
    logic [NUM_RD-1:0]                 rready1, rready2;
    logic [NUM_ALLOC-1:0]              alloc_valid;
    logic [NUM_ALLOC-1:0][PHYS_W-1:0]  alloc_pd;
    logic [NUM_ALLOC-1:0][EPOCH_W-1:0] alloc_epoch;
    logic [NUM_WB-1:0]                 wb_valid;
    logic [NUM_WB-1:0][PHYS_W-1:0]     wb_pd;
    logic [NUM_WB-1:0][DW-1:0]         wb_data;
    logic [NUM_WB-1:0][EPOCH_W-1:0]    wb_epoch;
    logic                              sweep_start;
    logic [EPOCH_W-1:0]                sweep_epoch;
    logic                              sweep_busy;
    logic                              wb_conflict;
    logic [PHYS_REGS-1:0]              ready_vec;

    prf_mp #(
        .PHYS_REGS(PHYS_REGS), .DW(DW), .NUM_RD(NUM_RD), .NUM_WB(NUM_WB),
        .NUM_ALLOC(NUM_ALLOC), .EPOCH_W(EPOCH_W), .SWEEP_PER_CYC(SPC)
    ) dut (
        .clk(clk), .rst(rst),
        .raddr1(raddr1), .rdata1(rdata1), .rready1(rready1),
        .raddr2(raddr2), .rdata2(rdata2), .rready2(rready2),
        .alloc_valid(alloc_valid), .alloc_pd(alloc_pd), .alloc_epoch(alloc_epoch),
        .wb_valid(wb_valid), .wb_pd(wb_pd), .wb_data(wb_data), .wb_epoch(wb_epoch),
        .sweep_start(sweep_start), .sweep_epoch(sweep_epoch),
        .sweep_busy(sweep_busy), .wb_conflict(wb_conflict), .ready_vec(ready_vec)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [NUM_RD-1:0][DW-1:0] d1;
        logic [NUM_RD-1:0]         r1;
        logic [NUM_RD-1:0][DW-1:0] d2;
        logic [NUM_RD-1:0]         r2;
        logic [PHYS_REGS-1:0]      rv;
        logic                      busy;
        logic                      conf;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state
    logic [DW-1:0]        mem_m [PHYS_REGS];
    logic [EPOCH_W-1:0]   ep_m  [PHYS_REGS];
    logic [PHYS_REGS-1:0] rdy_m;
    bit                   busy_m;
    int                   blk_m;
    logic [EPOCH_W-1:0]   sep_m;
    bit                   conf_m;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit acc(input int w);
        return wb_valid[w] && (wb_epoch[w] == ep_m[wb_pd[w]]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < PHYS_REGS; i++) begin
            mem_m[i] = '0;
            ep_m[i]  = '0;
        end
        rdy_m  = '1;
        busy_m = 1'b0;
        blk_m  = 0;
        sep_m  = '0;
        conf_m = 1'b0;
    endtask

    // Apply one clock edge to the model using the inputs currently driven.
    task automatic model_edge();
        logic [DW-1:0]        nmem [PHYS_REGS];
        logic [EPOCH_W-1:0]   nep  [PHYS_REGS];
        logic [PHYS_REGS-1:0] nrdy;
        bit                   win;
        int                   e;
        if (rst) begin
            model_reset();
            return;
        end
        nmem = mem_m;
        nep  = ep_m;
        nrdy = rdy_m;
        conf_m = 1'b0;
        for (int i = 0; i < NUM_WB; i++)
            for (int j = i + 1; j < NUM_WB; j++)
                if (acc(i) && acc(j) && wb_pd[i] == wb_pd[j]) conf_m = 1'b1;
        if (busy_m) begin
            for (int k = 0; k < SPC; k++) begin
                e = blk_m * SPC + k;
                if (!rdy_m[e] && ep_m[e] != sep_m) nrdy[e] = 1'b1;
            end
        end
        for (int a = 0; a < NUM_ALLOC; a++) begin
            if (alloc_valid[a]) begin
                nrdy[alloc_pd[a]] = 1'b0;
                win = 1'b1;
                for (int b = a + 1; b < NUM_ALLOC; b++)
                    if (alloc_valid[b] && alloc_pd[b] == alloc_pd[a]) win = 1'b0;
                if (win) nep[alloc_pd[a]] = alloc_epoch[a];
            end
        end
        for (int w = 0; w < NUM_WB; w++) begin
            if (acc(w)) begin
                nrdy[wb_pd[w]] = 1'b1;
                win = 1'b1;
                for (int v = 0; v < w; v++)
                    if (acc(v) && wb_pd[v] == wb_pd[w]) win = 1'b0;
                if (win) nmem[wb_pd[w]] = wb_data[w];
            end
        end
        if (busy_m) begin
            blk_m++;
            if (blk_m == NBLK) busy_m = 1'b0;
        end else if (sweep_start) begin
            busy_m = 1'b1;
            blk_m  = 0;
            sep_m  = sweep_epoch;
        end
        mem_m = nmem;
        ep_m  = nep;
        rdy_m = nrdy;
    endtask

    function automatic logic [DW:0] predict_read(input logic [PHYS_W-1:0] a);
        logic [DW-1:0] d;
        logic          r;
        d = mem_m[a];
        r = rdy_m[a];
`ifdef PRF_BYPASS_EN
        for (int w = NUM_WB - 1; w >= 0; w--) begin
            if (acc(w) && wb_pd[w] == a) begin
                d = wb_data[w];
                r = 1'b1;
            end
        end
`endif
        return {r, d};
    endfunction

    // Push the expected outputs for the current inputs and model state.
    task automatic expect_now();
        exp_t          x;
        logic [DW:0]   rd;
        for (int p = 0; p < NUM_RD; p++) begin
            rd = predict_read(raddr1[p]);
            x.d1[p] = rd[DW-1:0];
            x.r1[p] = rd[DW];
            rd = predict_read(raddr2[p]);
            x.d2[p] = rd[DW-1:0];
            x.r2[p] = rd[DW];
        end
        x.rv   = rdy_m;
        x.busy = busy_m;
        x.conf = conf_m;
        sb_q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic idle_inputs();
        alloc_valid = '0;
        wb_valid    = '0;
        sweep_start = 1'b0;
    endtask

    // Monitor: compare DUT outputs to the queued prediction mid-cycle.
    always @(negedge clk) begin
        exp_t x;
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            check("rdata1", rdata1, x.d1);
            check("rready1", rready1, x.r1);
            check("rdata2", rdata2, x.d2);
            check("rready2", rready2, x.r2);
            check("ready_vec", ready_vec, x.rv);
            check("sweep_busy", sweep_busy, x.busy);
            check("wb_conflict", wb_conflict, x.conf);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pd;
        logic [PHYS_REGS-1:0] ones;
        ones = '1;
        raddr1 = '0;
        raddr2 = '0;
        alloc_pd = '0;
        alloc_epoch = '0;
        wb_pd = '0;
        wb_data = '0;
        wb_epoch = '0;
        sweep_epoch = '0;
        idle_inputs();
        rst = 1'b1;
        raddr1[0] = PHYS_W'(5);
        model_reset();
        @(posedge clk);
        #1;
        expect_now(); tick();
        expect_now(); tick();

        // Reset state
        rst = 1'b0;
        expect_now();
        #1;
        check("reset_rdata_pd5", rdata1[0], 32'h0);
        check("reset_rready_pd5", rready1[0], 1'b1);
        check("reset_ready_vec", ready_vec, ones);
        tick();

        // Alloc then matching writeback, then a stale one
        idle_inputs();
        alloc_valid[0] = 1'b1; alloc_pd[0] = PHYS_W'(7); alloc_epoch[0] = EPOCH_W'(1);
        expect_now(); tick();
        idle_inputs();
        wb_valid[0] = 1'b1; wb_pd[0] = PHYS_W'(7); wb_epoch[0] = EPOCH_W'(1);
        wb_data[0] = 32'hDEADBEEF; raddr1[0] = PHYS_W'(7);
        expect_now(); tick();
        idle_inputs();
        wb_valid[0] = 1'b1; wb_pd[0] = PHYS_W'(7); wb_epoch[0] = EPOCH_W'(0);
        wb_data[0] = 32'h0BAD0BAD;
        expect_now();
        #1;
        check("wb_accept_rdata", rdata1[0], 32'hDEADBEEF);
        check("wb_accept_rready", rready1[0], 1'b1);
        tick();
        idle_inputs();
        expect_now();
        #1;
        check("stale_wb_dropped", rdata1[0], 32'hDEADBEEF);
        tick();

        // Two accepted writebacks to the same entry
        idle_inputs();
        wb_valid = 2'b11;
        wb_pd[0] = PHYS_W'(9); wb_epoch[0] = EPOCH_W'(0); wb_data[0] = 32'h11;
        wb_pd[1] = PHYS_W'(9); wb_epoch[1] = EPOCH_W'(0); wb_data[1] = 32'h22;
        expect_now(); tick();
        idle_inputs();
        raddr1[0] = PHYS_W'(9);
        expect_now();
        #1;
        check("dup_wb_low_wins", rdata1[0], 32'h11);
        check("wb_conflict_pulse", wb_conflict, 1'b1);
        tick();
        idle_inputs();
        expect_now();
        #1;
        check("wb_conflict_one_cycle", wb_conflict, 1'b0);
        tick();

        // Orphan sweep
        idle_inputs();
        alloc_valid = 2'b11;
        alloc_pd[0] = PHYS_W'(3); alloc_epoch[0] = EPOCH_W'(2);
        alloc_pd[1] = PHYS_W'(4); alloc_epoch[1] = EPOCH_W'(1);
        expect_now(); tick();
        idle_inputs();
        sweep_start = 1'b1; sweep_epoch = EPOCH_W'(1);
        expect_now(); tick();
        idle_inputs();
        n = 0;
        while (sweep_busy && n < 20) begin
            n++;
            expect_now(); tick();
        end
        check("sweep_busy_cycles", n, 8);
        check("sweep_orphan_ready", ready_vec[3], 1'b1);
        check("sweep_live_not_ready", ready_vec[4], 1'b0);

        // Same-cycle forwarding (or not) of a writeback to a reader
        idle_inputs();
        wb_valid[0] = 1'b1; wb_pd[0] = PHYS_W'(12); wb_epoch[0] = EPOCH_W'(0);
        wb_data[0] = 32'h55; raddr1[0] = PHYS_W'(12);
        expect_now();
        #1;
`ifdef PRF_BYPASS_EN
        check("bypass_rdata", rdata1[0], 32'h55);
        check("bypass_rready", rready1[0], 1'b1);
`else
        check("nobypass_rdata", rdata1[0], 32'h0);
`endif
        tick();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            idle_inputs();
            for (int a = 0; a < NUM_ALLOC; a++) begin
                alloc_valid[a] = ($urandom_range(0, 3) == 0);
                alloc_pd[a]    = PHYS_W'($urandom_range(0, 15));
                alloc_epoch[a] = EPOCH_W'($urandom);
            end
            for (int w = 0; w < NUM_WB; w++) begin
                pd = $urandom_range(0, 15);
                wb_valid[w] = 1'($urandom_range(0, 1));
                wb_pd[w]    = PHYS_W'(pd);
                wb_epoch[w] = ($urandom_range(0, 3) != 0) ? ep_m[pd] : EPOCH_W'($urandom);
                wb_data[w]  = $urandom;
            end
            sweep_start = ($urandom_range(0, 19) == 0);
            sweep_epoch = EPOCH_W'($urandom);
            for (int p = 0; p < NUM_RD; p++) begin
                raddr1[p] = PHYS_W'($urandom_range(0, 15));
                raddr2[p] = PHYS_W'($urandom_range(0, PHYS_REGS - 1));
            end
            expect_now(); tick();
        end

        // Reset in the middle of a sweep
        idle_inputs();
        n = 0;
        while (busy_m && n < 20) begin
            n++;
            expect_now(); tick();
        end
        sweep_start = 1'b1; sweep_epoch = EPOCH_W'(3);
        expect_now(); tick();
        idle_inputs();
        expect_now(); tick();
        expect_now(); tick();
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_sweep_busy", sweep_busy, 1'b0);
        check("rst_mid_sweep_ready", ready_vec, ones);
        model_reset();
        expect_now(); tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            idle_inputs();
            for (int p = 0; p < NUM_RD; p++) raddr2[p] = PHYS_W'($urandom_range(0, PHYS_REGS - 1));
            expect_now(); tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
